// File: rtl/stoch_est_mat.sv
// Stochastic-to-binary estimator: counts ones per matrix element over 2^WINDOW_BITS accepted samples.
// Optional macro STOCH_EST_CONTINUOUS_EN keeps the block in RUN and starts back-to-back windows.
module stoch_est_mat #(
   parameter int NUM_ROWS    = 2,
   parameter int NUM_COLS    = 2,
   parameter int WINDOW_BITS = 8,
   parameter int COUNT_WIDTH = WINDOW_BITS + 1
) (
   input  logic                                         CLK,
   input  logic                                         RST,
   input  logic                                         START,
   input  logic                                         EN,
   input  logic [NUM_ROWS*NUM_COLS-1:0]                 A,
   output logic [NUM_ROWS*NUM_COLS*COUNT_WIDTH-1:0]     Y,
   output logic                                         VALID,
   output logic                                         BUSY
);

   localparam int NUM_ELEM = NUM_ROWS * NUM_COLS;
   localparam logic [WINDOW_BITS-1:0] CNT_ONE = WINDOW_BITS'(1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                  state_q;
   logic [WINDOW_BITS-1:0]  cnt_q;
   logic                    valid_q;
   logic                    busy_q;
   logic [COUNT_WIDTH-1:0]  acc_q [NUM_ELEM];
   logic [COUNT_WIDTH-1:0]  y_q   [NUM_ELEM];

   logic accept;
   logic win_end;
   logic clear;

   // START always wins over a sample on the same edge, so that edge is never counted.
   assign accept  = (state_q == RUN) && EN && !START;
   assign win_end = accept && (cnt_q == '1);
   assign clear   = START || win_end;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (START) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               if (START) begin
                  cnt_q <= '0;
               end else if (accept) begin
                  cnt_q <= cnt_q + CNT_ONE;
                  if (win_end) begin
                     valid_q <= 1'b1;
`ifndef STOCH_EST_CONTINUOUS_EN
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
`endif
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
         logic [COUNT_WIDTH-1:0] sum_d;
         assign sum_d = acc_q[gi] + COUNT_WIDTH'(A[gi]);

         always_ff @(posedge CLK) begin
            if (RST) begin
               acc_q[gi] <= '0;
               y_q[gi]   <= '0;
            end else begin
               if (clear) begin
                  acc_q[gi] <= '0;
               end else if (accept) begin
                  acc_q[gi] <= sum_d;
               end
               // Final sample folds straight into the published count.
               if (win_end) begin
                  y_q[gi] <= sum_d;
               end
            end
         end

         assign Y[gi*COUNT_WIDTH +: COUNT_WIDTH] = y_q[gi];
      end
   endgenerate

   assign VALID = valid_q;
   assign BUSY  = busy_q;

endmodule
